// File: rtl/safecrack_pkg.sv
// Shared definitions for the safe-lock front end and lock FSM.
// BTN_IDLE is the "no event" code the lock FSM compares against.
package safecrack_pkg;

    localparam logic [3:0] BTN_IDLE = 4'b1111;

    typedef enum logic {
        IDLE,
        WAIT_REL
    } btn_evt_state_t;

    // Number of clocks a key level must hold before it is accepted.
    function automatic int unsigned deb_cycles(input int unsigned clk_hz,
                                               input int unsigned us);
        return (clk_hz / 32'd1_000_000) * us;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One key: two-flop synchroniser followed by a stable-time debounce counter.
// o_stable only follows the synchronised level after it has disagreed with
// the accepted level for DEB_CYCLES consecutive clocks.
module btn_debounce #(
    parameter int unsigned DEB_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int unsigned CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic [CW-1:0] r_cnt;

    // Bring the asynchronous key into the clock domain; idle (released) is 1.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive disagreeing clocks; any agreement restarts the count.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/btn_conditioner.sv
// Key conditioner for the safe-lock FSM: debounces four active-low keys and
// emits a one-clock active-low one-hot code per press, rejecting chords and
// requiring full release between presses.
// Optional macro BTN_COND_PRESS_CNT_EN adds an 8-bit press_count output.
module btn_conditioner
    import safecrack_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned DEBOUNCE_US = 20_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn,
    output logic [3:0] btn_stable,
    output logic       multi_press
`ifdef BTN_COND_PRESS_CNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int unsigned DEB_CYCLES = deb_cycles(CLK_HZ, DEBOUNCE_US);

    logic [3:0]     w_stable;
    logic [2:0]     w_zero_cnt;
    logic           w_one_key;
    logic           w_chord;

    btn_evt_state_t r_state;
    logic [3:0]     r_btn;
    logic           r_multi;
`ifdef BTN_COND_PRESS_CNT_EN
    logic [7:0]     r_press_cnt;
`endif

    for (genvar g = 0; g < 4; g++) begin : g_key
        btn_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .i_clk    (clk),
            .i_rst_n  (rst),
            .i_raw    (btn_raw[g]),
            .o_stable (w_stable[g])
        );
    end

    // Number of keys currently held down (debounced).
    always_comb begin
        w_zero_cnt = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            w_zero_cnt = w_zero_cnt + {2'b00, ~w_stable[i]};
        end
    end

    assign w_one_key = (w_zero_cnt == 3'd1);
    assign w_chord   = (w_zero_cnt >= 3'd2);

    // Event FSM: one registered pulse per press, then wait for full release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_btn       <= BTN_IDLE;
            r_multi     <= 1'b0;
`ifdef BTN_COND_PRESS_CNT_EN
            r_press_cnt <= '0;
`endif
        end else begin
            r_btn   <= BTN_IDLE;
            r_multi <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_one_key) begin
                        r_btn   <= w_stable;
                        r_state <= WAIT_REL;
`ifdef BTN_COND_PRESS_CNT_EN
                        r_press_cnt <= r_press_cnt + 8'd1;
`endif
                    end else if (w_chord) begin
                        r_multi <= 1'b1;
                        r_state <= WAIT_REL;
                    end
                end
                WAIT_REL: begin
                    if (w_stable == BTN_IDLE) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign btn         = r_btn;
    assign btn_stable  = w_stable;
    assign multi_press = r_multi;
`ifdef BTN_COND_PRESS_CNT_EN
    assign press_count = r_press_cnt;
`endif

endmodule
